// File: rtl/stack_exec_if.sv
// Instruction handshake and attached-stack strobe bus for stack_exec.
// The slave side is the executor; the master side is the host plus the stack.
interface stack_exec_if #(parameter int DEPTH = 16);
  localparam int DW = $clog2(DEPTH + 1);

  logic          ins_valid;
  logic          ins_ready;
  logic [3:0]    ins_op;
  logic [15:0]   ins_imm;
  logic [15:0]   qtop;
  logic [15:0]   qnext;
  logic          load;
  logic          push;
  logic          pop;
  logic [15:0]   d;
  logic          done;
  logic          err;
  logic [DW-1:0] depth;

  modport slave (
    input  ins_valid, ins_op, ins_imm, qtop, qnext,
    output ins_ready, load, push, pop, d, done, err, depth
  );

  modport master (
    output ins_valid, ins_op, ins_imm, qtop, qnext,
    input  ins_ready, load, push, pop, d, done, err, depth
  );
endinterface

// File: rtl/stack_exec.sv
// Stack-machine instruction executor: latches operands at acceptance, then
// drives push/pop/load strobes to an external stack and tracks its occupancy.
module stack_exec #(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  stack_exec_if.slave  bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  typedef enum logic [2:0] {IDLE, S1, S2, S3, MUL} state_e;
  typedef enum logic [3:0] {
    OP_NOP, OP_PUSH, OP_POP, OP_DUP, OP_SWAP, OP_ADD, OP_SUB, OP_AND,
    OP_OR, OP_XOR, OP_NOT, OP_INC, OP_SHL1, OP_MUL, OP_ILL_E, OP_ILL_F
  } op_e;

  state_e        state_q, state_d;
  op_e           op_q, op_in;
  logic [15:0]   imm_q, t_q, n_q, prod_q;
  logic [3:0]    cnt_q;
  logic          skip_q, err_q;
  logic [DW-1:0] depth_q, depth_d;
  logic [1:0]    need;
  logic          acc_err, acc_skip;
  logic [15:0]   una, bin;

  // Acceptance-time decode: operand demand and error classification.
  always_comb begin
    op_in = op_e'(bus.ins_op);
    need  = 2'd0;
    case (op_in)
      OP_POP, OP_DUP, OP_NOT, OP_INC, OP_SHL1: need = 2'd1;
      OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL: need = 2'd2;
      default: need = 2'd0;
    endcase
    acc_err  = (op_in == OP_ILL_E) || (op_in == OP_ILL_F) ||
               (depth_q < DW'(need)) ||
               ((op_in == OP_PUSH || op_in == OP_DUP) && depth_q == FULL);
    acc_skip = acc_err || (op_in == OP_NOP);
  end

  always_comb begin
    case (op_q)
      OP_NOT:  una = ~t_q;
      OP_INC:  una = t_q + 16'd1;
      default: una = {t_q[14:0], 1'b0};
    endcase
    case (op_q)
      OP_ADD:  bin = n_q + t_q;
      OP_SUB:  bin = n_q - t_q;
      OP_AND:  bin = n_q & t_q;
      OP_OR:   bin = n_q | t_q;
      OP_XOR:  bin = n_q ^ t_q;
      default: bin = prod_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    bus.ins_ready = (state_q == IDLE);
    bus.load      = 1'b0;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.d         = 16'h0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    case (state_q)
      IDLE: if (bus.ins_valid) state_d = (!acc_skip && op_in == OP_MUL) ? MUL : S1;
      S1: begin
        state_d = IDLE;
        // NOP and rejected instructions complete here without touching the stack.
        if (skip_q) begin
          bus.done = 1'b1;
          bus.err  = err_q;
        end else begin
          case (op_q)
            OP_PUSH: begin bus.push = 1'b1; bus.d = imm_q; bus.done = 1'b1; end
            OP_DUP:  begin bus.push = 1'b1; bus.d = t_q;   bus.done = 1'b1; end
            OP_POP:  begin bus.pop  = 1'b1;                bus.done = 1'b1; end
            OP_NOT, OP_INC, OP_SHL1: begin
              bus.load = 1'b1; bus.d = una; bus.done = 1'b1;
            end
            default: begin bus.pop = 1'b1; state_d = S2; end
          endcase
        end
      end
      S2: begin
        bus.load = 1'b1;
        if (op_q == OP_SWAP) begin
          bus.d   = t_q;
          state_d = S3;
        end else begin
          bus.d    = bin;
          bus.done = 1'b1;
          state_d  = IDLE;
        end
      end
      S3: begin
        bus.push = 1'b1;
        bus.d    = n_q;
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      MUL:     if (cnt_q == 4'd15) state_d = S1;
      default: state_d = IDLE;
    endcase
  end

  assign depth_d   = depth_q + DW'(bus.push) - DW'(bus.pop);
  assign bus.depth = depth_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      imm_q   <= 16'h0;
      t_q     <= 16'h0;
      n_q     <= 16'h0;
      prod_q  <= 16'h0;
      cnt_q   <= 4'd0;
      skip_q  <= 1'b0;
      err_q   <= 1'b0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      if (state_q == IDLE && bus.ins_valid) begin
        op_q   <= op_in;
        imm_q  <= bus.ins_imm;
        t_q    <= bus.qtop;
        n_q    <= bus.qnext;
        skip_q <= acc_skip;
        err_q  <= acc_err;
        prod_q <= 16'h0;
        cnt_q  <= 4'd0;
      end else if (state_q == MUL) begin
        // Shift-add: T supplies multiplier bits LSB first, N is the shifted multiplicand.
        if (t_q[0]) prod_q <= prod_q + n_q;
        n_q   <= {n_q[14:0], 1'b0};
        t_q   <= {1'b0, t_q[15:1]};
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_stack_exec.sv
// Randomized scoreboard bench for stack_exec with a behavioural stack model.
module tb_stack_exec;
  localparam int DEPTH = 16;

  typedef struct {
    bit          err;
    int          nstr;
    int          lat;
    int          depth;
    logic [15:0] top;
    logic [15:0] nxt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  stack_exec_if #(.DEPTH(DEPTH)) bus();
  stack_exec #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] ref_stk[$];
  logic [15:0] env_stk[$];
  exp_t        sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Attached stack: reacts to DUT strobes, presents top/next.
  initial begin
    bus.qtop  = 16'h0;
    bus.qnext = 16'h0;
    forever begin
      @(posedge clk);
      if (reset) env_stk.delete();
      else if (bus.push) env_stk.push_back(bus.d);
      else if (bus.pop) begin
        if (env_stk.size() > 0) void'(env_stk.pop_back());
      end else if (bus.load && env_stk.size() > 0) begin
        void'(env_stk.pop_back());
        env_stk.push_back(bus.d);
      end
      bus.qtop  <= (env_stk.size() > 0) ? env_stk[env_stk.size()-1] : 16'h0;
      bus.qnext <= (env_stk.size() > 1) ? env_stk[env_stk.size()-2] : 16'h0;
    end
  end

  // Monitor: per-cycle invariants, and scoreboard pop on each done pulse.
  initial begin
    int   busy = 0;
    int   nstr = 0;
    bit   post = 0;
    int   sz;
    exp_t pe, e;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 0; nstr = 0; post = 0;
      end else begin
        if (post) begin
          post = 0;
          sz = env_stk.size();
          chk("depth", bus.depth, pe.depth);
          chk("stk_size", sz, pe.depth);
          if (sz > 0 && pe.depth > 0) chk("stk_top", env_stk[sz-1], pe.top);
          if (sz > 1 && pe.depth > 1) chk("stk_next", env_stk[sz-2], pe.nxt);
        end
        chk("strobe_excl", (int'(bus.load) + int'(bus.push) + int'(bus.pop)) <= 1, 1);
        if (!bus.load && !bus.push) chk("d_idle", bus.d, 0);
        chk("err_qual", bus.err & ~bus.done, 0);
        if (!bus.ins_ready) begin
          busy++;
          nstr += int'(bus.load) + int'(bus.push) + int'(bus.pop);
        end
        if (bus.done) begin
          chk("done_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("err", bus.err, e.err);
            chk("strobes", nstr, e.nstr);
            chk("busy_cycles", busy, e.lat);
            pe = e; post = 1;
          end
          busy = 0; nstr = 0;
        end
      end
    end
  end

  function automatic logic [15:0] alu2(input logic [3:0] op, input logic [15:0] n, input logic [15:0] t);
    logic [31:0] p;
    p = {16'h0, n} * {16'h0, t};
    case (op)
      4'h5:    return n + t;
      4'h6:    return n - t;
      4'h7:    return n & t;
      4'h8:    return n | t;
      4'h9:    return n ^ t;
      default: return p[15:0];
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [15:0] imm, input bit track);
    exp_t        e;
    int          sz, need, w;
    logic [15:0] t, n;
    @(negedge clk);
    w = 0;
    while (!bus.ins_ready && w < 64) begin @(negedge clk); w++; end
    chk("ins_ready", bus.ins_ready, 1);
    bus.ins_valid = 1'b1;
    bus.ins_op    = op;
    bus.ins_imm   = imm;
    @(posedge clk);
    #1;
    bus.ins_valid = 1'b0;
    bus.ins_op    = 4'($urandom);
    bus.ins_imm   = 16'($urandom);
    if (track) begin
      sz   = ref_stk.size();
      t    = (sz > 0) ? ref_stk[sz-1] : 16'h0;
      n    = (sz > 1) ? ref_stk[sz-2] : 16'h0;
      need = (op inside {4'h2, 4'h3, 4'hA, 4'hB, 4'hC}) ? 1 :
             (op inside {[4'h4:4'h9], 4'hD}) ? 2 : 0;
      e.err  = (op >= 4'hE) || (sz < need) || ((op == 4'h1 || op == 4'h3) && sz == DEPTH);
      e.nstr = 0;
      e.lat  = 1;
      if (!e.err) begin
        case (op)
          4'h1: begin ref_stk.push_back(imm); e.nstr = 1; end
          4'h2: begin void'(ref_stk.pop_back()); e.nstr = 1; end
          4'h3: begin ref_stk.push_back(t); e.nstr = 1; end
          4'h4: begin ref_stk[sz-1] = n; ref_stk[sz-2] = t; e.nstr = 3; e.lat = 3; end
          4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hD: begin
            void'(ref_stk.pop_back());
            ref_stk[sz-2] = alu2(op, n, t);
            e.nstr = 2;
            e.lat  = (op == 4'hD) ? 18 : 2;
          end
          4'hA: begin ref_stk[sz-1] = ~t; e.nstr = 1; end
          4'hB: begin ref_stk[sz-1] = t + 16'd1; e.nstr = 1; end
          4'hC: begin ref_stk[sz-1] = t << 1; e.nstr = 1; end
          default: ;
        endcase
      end
      sz      = ref_stk.size();
      e.depth = sz;
      e.top   = (sz > 0) ? ref_stk[sz-1] : 16'h0;
      e.nxt   = (sz > 1) ? ref_stk[sz-2] : 16'h0;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ref_stk.delete();
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() > 0 || !bus.ins_ready) && w < 64) begin @(negedge clk); w++; end
    chk("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] op;
    bus.ins_valid = 1'b0;
    bus.ins_op    = 4'h0;
    bus.ins_imm   = 16'h0;
    do_reset();
    @(negedge clk);
    chk("rst_ready", bus.ins_ready, 1);
    chk("rst_depth", bus.depth, 0);
    chk("rst_strobes", {bus.load, bus.push, bus.pop}, 0);
    chk("rst_d", bus.d, 0);
    chk("rst_done", {bus.done, bus.err}, 0);

    issue(4'h1, 16'h1111, 1); issue(4'h1, 16'h2222, 1); issue(4'h5, 16'h0, 1); drain();
    do_reset();
    issue(4'h1, 16'h0005, 1); issue(4'h1, 16'h0007, 1); issue(4'h6, 16'h0, 1);
    issue(4'h1, 16'hFFFF, 1); issue(4'hB, 16'h0, 1); drain();
    do_reset();
    issue(4'h1, 16'h1234, 1); issue(4'h1, 16'h5678, 1); issue(4'h4, 16'h0, 1); drain();
    do_reset();
    issue(4'h1, 16'h0001, 1); issue(4'h5, 16'h0, 1); drain();
    do_reset();
    repeat (DEPTH) issue(4'h1, 16'($urandom), 1);
    issue(4'h1, 16'hBEEF, 1); issue(4'h3, 16'h0, 1); issue(4'hF, 16'h0, 1); issue(4'hE, 16'h0, 1);
    drain();
    do_reset();
    issue(4'h1, 16'h0100, 1); issue(4'h1, 16'h0101, 1); issue(4'hD, 16'h0, 1); drain();

    do_reset();
    repeat (400) begin
      op = ($urandom_range(0, 99) < 30) ? 4'h1 : 4'($urandom_range(0, 15));
      issue(op, 16'($urandom), 1);
    end
    drain();

    do_reset();
    issue(4'h1, 16'h0003, 1); issue(4'h1, 16'h0005, 1); drain();
    issue(4'hD, 16'h0, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    ref_stk.delete();
    sb.delete();
    @(negedge clk);
    chk("abort_strobes", {bus.load, bus.push, bus.pop}, 0);
    chk("abort_depth", bus.depth, 0);
    chk("abort_done", bus.done, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", bus.ins_ready, 1);
    repeat (20) begin
      @(negedge clk);
      chk("abort_no_done", bus.done, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
